// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings,
// timing compare values and the refresh FSM state type.
package sdram_pkg;

    localparam logic [3:0] NOP       = 4'b0111;
    localparam logic [3:0] P_CHARGE  = 4'b0010;
    localparam logic [3:0] AUTO_REF  = 4'b0001;
    localparam logic [3:0] M_REG_SET = 4'b0000;

    localparam logic [2:0] TRP_CLK  = 3'd2;
    localparam logic [2:0] TRC_CLK  = 3'd7;
    localparam logic [2:0] TMRD_CLK = 3'd3;

    // 7.5 us at 100 MHz, minus one
    localparam logic [9:0] CNT_REF_MAX_DEF = 10'd749;

    localparam logic [1:0]  BA_ALL   = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1fff;

    typedef enum logic [2:0] {
        AREF_IDLE = 3'd0,
        AREF_PCHA = 3'd1,
        AREF_TRP  = 3'd2,
        AREF_AR   = 3'd3,
        AREF_TRF  = 3'd4,
        AREF_END  = 3'd5
    } aref_state_t;

endpackage

// File: rtl/sdram_a_ref.sv
// Periodic auto-refresh generator: interval timer, arbiter
// request and precharge-all plus AREF_NUM auto-refresh sequence.
module sdram_a_ref
    import sdram_pkg::*;
#(
    parameter logic [9:0] CNT_REF_MAX = CNT_REF_MAX_DEF,
    parameter logic [1:0] AREF_NUM    = 2'd2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

    aref_state_t r_state;
    logic [9:0]  r_cnt_ref;
    logic [2:0]  r_cnt_clk;
    logic [1:0]  r_cnt_aref;

    logic w_trp_hit;
    logic w_trc_hit;
    logic w_ref_hit;

    assign w_trp_hit = (r_state == AREF_TRP)
                    && (r_cnt_clk == TRP_CLK);
    assign w_trc_hit = (r_state == AREF_TRF)
                    && (r_cnt_clk == TRC_CLK);
    assign w_ref_hit = (r_cnt_ref == CNT_REF_MAX);

    // Free-running interval timer; a refresh never pauses it
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_cnt_ref <= '0;
        else if (!init_end)
            r_cnt_ref <= '0;
        else if (w_ref_hit)
            r_cnt_ref <= '0;
        else
            r_cnt_ref <= r_cnt_ref + 10'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            aref_req <= 1'b0;
        else if (w_ref_hit)
            aref_req <= 1'b1;
        else if ((r_state == AREF_IDLE) && aref_en)
            aref_req <= 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_cnt_clk <= '0;
        else if ((r_state == AREF_IDLE)
              || (r_state == AREF_END)
              || w_trp_hit || w_trc_hit)
            r_cnt_clk <= '0;
        else
            r_cnt_clk <= r_cnt_clk + 3'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_cnt_aref <= '0;
        else if (r_state == AREF_IDLE)
            r_cnt_aref <= '0;
        else if (r_state == AREF_AR)
            r_cnt_aref <= r_cnt_aref + 2'd1;
    end

    // Commands are registered from the current state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= AREF_IDLE;
            aref_cmd  <= NOP;
            aref_ba   <= BA_ALL;
            aref_addr <= ADDR_ALL;
        end else begin
            aref_ba   <= BA_ALL;
            aref_addr <= ADDR_ALL;
            case (r_state)
                AREF_IDLE: begin
                    aref_cmd <= NOP;
                    if (aref_en && aref_req)
                        r_state <= AREF_PCHA;
                end
                AREF_PCHA: begin
                    aref_cmd <= P_CHARGE;
                    r_state  <= AREF_TRP;
                end
                AREF_TRP: begin
                    aref_cmd <= NOP;
                    if (w_trp_hit)
                        r_state <= AREF_AR;
                end
                AREF_AR: begin
                    aref_cmd <= AUTO_REF;
                    r_state  <= AREF_TRF;
                end
                AREF_TRF: begin
                    aref_cmd <= NOP;
                    if (w_trc_hit) begin
                        if (r_cnt_aref == AREF_NUM)
                            r_state <= AREF_END;
                        else
                            r_state <= AREF_AR;
                    end
                end
                AREF_END: begin
                    aref_cmd <= NOP;
                    r_state  <= AREF_IDLE;
                end
                default: begin
                    aref_cmd <= NOP;
                    r_state  <= AREF_IDLE;
                end
            endcase
        end
    end

    assign aref_end = (r_state == AREF_END);

endmodule

// File: tb/tb_sdram_a_ref.sv
// Randomised bench for sdram_a_ref against an event-schedule
// model of the refresh interval and command sequence.
module tb_sdram_a_ref;

    localparam int MAXC = 749;
    localparam int NAR  = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        aref_en = 1'b0;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_end;

    sdram_a_ref dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .init_end  (init_end),
        .aref_en   (aref_en),
        .aref_req  (aref_req),
        .aref_cmd  (aref_cmd),
        .aref_ba   (aref_ba),
        .aref_addr (aref_addr),
        .aref_end  (aref_end)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    // Model: interval counter plus a schedule of events
    // measured in edges since the grant was accepted.
    int m_cnt = 0;
    int m_rel = 0;
    bit m_req = 1'b0;
    bit m_busy = 1'b0;
    bit t_idle;
    bit t_nreq;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_cnt  = 0;
            m_rel  = 0;
            m_req  = 1'b0;
            m_busy = 1'b0;
        end else begin
            t_idle = !m_busy;
            if (m_cnt == MAXC)
                t_nreq = 1'b1;
            else if (t_idle && aref_en)
                t_nreq = 1'b0;
            else
                t_nreq = m_req;
            if (m_busy) begin
                m_rel++;
                if (m_rel == 4 + 8 * NAR)
                    m_busy = 1'b0;
            end else if (aref_en && m_req) begin
                m_busy = 1'b1;
                m_rel  = 0;
            end
            if (!init_end)
                m_cnt = 0;
            else
                m_cnt = (m_cnt == MAXC) ? 0 : m_cnt + 1;
            m_req = t_nreq;
        end
    end

    function automatic logic [3:0] exp_cmd();
        if (!m_busy)
            return 4'b0111;
        if (m_rel == 1)
            return 4'b0010;
        for (int k = 0; k < NAR; k++)
            if (m_rel == 4 + 8 * k)
                return 4'b0001;
        return 4'b0111;
    endfunction

    function automatic logic exp_end();
        return m_busy && (m_rel == 3 + 8 * NAR);
    endfunction

    always @(negedge sys_clk) begin
        if (chk_on && sys_rst_n) begin
            chk("req", aref_req, m_req);
            chk("cmd", aref_cmd, exp_cmd());
            chk("ba", aref_ba, 2'b11);
            chk("addr", aref_addr, 13'h1fff);
            chk("end", aref_end, exp_end());
        end
    end

    task automatic edges_to_req(string name);
        int n;
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge sys_clk);
            #1;
            if (aref_req) begin
                n = i;
                break;
            end
        end
        chk(name, n, 750);
    endtask

    int p_at, ar1, ar2, e_at, np, last_p;
    bit got;

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_cmd", aref_cmd, 4'b0111);
        chk("rst_req", aref_req, 1'b0);
        chk("rst_ba", aref_ba, 2'b11);
        chk("rst_addr", aref_addr, 13'h1fff);
        chk("rst_end", aref_end, 1'b0);
        sys_rst_n = 1'b1;
        chk_on = 1'b1;

        // init_end low: grants with no request are ignored
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            aref_en = ($urandom_range(0, 3) == 0);
        end
        @(negedge sys_clk);
        aref_en = 1'b0;
        chk("pre_init_req", aref_req, 1'b0);

        init_end = 1'b1;
        edges_to_req("init_to_req");
        repeat ($urandom_range(5, 40)) @(negedge sys_clk);

        aref_en = 1'b1;
        @(negedge sys_clk);
        aref_en = 1'b0;
        chk("req_drop", aref_req, 1'b0);
        p_at = -1; ar1 = -1; ar2 = -1; e_at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge sys_clk);
            if (aref_cmd == 4'b0010 && p_at < 0)
                p_at = i;
            if (aref_cmd == 4'b0001) begin
                if (ar1 < 0)
                    ar1 = i;
                else if (ar2 < 0)
                    ar2 = i;
            end
            if (aref_end && e_at < 0)
                e_at = i;
        end
        chk("pcha_at", p_at, 1);
        chk("ar1_at", ar1, 4);
        chk("ar2_at", ar2, 12);
        chk("end_at", e_at, 19);

        // grant held high: one sequence per interval
        aref_en = 1'b1;
        np = 0;
        last_p = -1;
        for (int i = 0; i < 2400; i++) begin
            @(negedge sys_clk);
            if (aref_cmd == 4'b0010) begin
                if (last_p >= 0)
                    chk("pcha_gap", i - last_p, 750);
                last_p = i;
                np++;
            end
        end
        chk("pcha_count", np, 3);

        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            aref_en = ($urandom_range(0, 3) == 0);
        end

        aref_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (m_busy && m_rel == 6) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait_trf", got, 1'b1);
        aref_en = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_cmd", aref_cmd, 4'b0111);
        chk("arst_req", aref_req, 1'b0);
        chk("arst_end", aref_end, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        edges_to_req("rst_to_req");
        repeat (20) @(negedge sys_clk);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
